// File: rtl/iter_multdiv.sv
// Multi-cycle signed multiply (radix-4 Booth) / divide (non-restoring) unit.
// Start pulses abort any operation in flight; results are strobed once by data_resultRDY.
module iter_multdiv #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned MULT_CYCLES = WIDTH / 2,
    parameter int unsigned DIV_CYCLES  = WIDTH
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY
);

    localparam int unsigned CW = $clog2(DIV_CYCLES + 1);
    localparam int unsigned PW = 2 * WIDTH + 2;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t           state;
    logic [CW-1:0]    counter;
    logic [WIDTH-1:0] a_reg;
    logic [PW-1:0]    prod;
    logic [WIDTH:0]   rem;
    logic [WIDTH-1:0] quot;
    logic [WIDTH-1:0] bmag;
    logic             neg;
    logic             div_zero;
    logic             div_ovf;
    logic             op_div;

    logic [WIDTH+1:0] a_ext;
    logic [WIDTH+1:0] addend;
    logic [WIDTH+1:0] sum_mul;
    logic [PW-1:0]    prod_next;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   rem_next;
    logic [WIDTH-1:0] quot_next;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic [WIDTH-1:0] div_q;
    logic             mul_exc;

    // Booth step: add 0/+-A/+-2A to the upper part, then arithmetic shift right by 2
    always_comb begin
        a_ext  = {{2{a_reg[WIDTH-1]}}, a_reg};
        addend = '0;
        case (prod[2:0])
            3'b001, 3'b010: addend = a_ext;
            3'b011:         addend = {a_ext[WIDTH:0], 1'b0};
            3'b100:         addend = -{a_ext[WIDTH:0], 1'b0};
            3'b101, 3'b110: addend = -a_ext;
            default:        addend = '0;
        endcase
        sum_mul   = {prod[PW-1], prod[PW-1:WIDTH+1]} + addend;
        prod_next = {sum_mul[WIDTH+1], sum_mul, prod[WIDTH:2]};
    end

    // Non-restoring step on magnitudes; quotient bit is the inverted remainder sign
    always_comb begin
        rem_sh    = {rem[WIDTH-1:0], quot[WIDTH-1]};
        rem_next  = rem[WIDTH] ? rem_sh + {1'b0, bmag} : rem_sh - {1'b0, bmag};
        quot_next = {quot[WIDTH-2:0], ~rem_next[WIDTH]};
    end

    always_comb begin
        abs_a   = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
        abs_b   = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
        div_q   = neg ? -quot : quot;
        mul_exc = (prod[2*WIDTH:WIDTH+1] != {WIDTH{prod[WIDTH]}});
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            counter        <= '0;
            a_reg          <= '0;
            prod           <= '0;
            rem            <= '0;
            quot           <= '0;
            bmag           <= '0;
            neg            <= 1'b0;
            div_zero       <= 1'b0;
            div_ovf        <= 1'b0;
            op_div         <= 1'b0;
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
        end else begin
            data_resultRDY <= 1'b0;
            if (ctrl_MULT || ctrl_DIV) begin
                counter  <= '0;
                a_reg    <= data_operandA;
                prod     <= {(WIDTH + 1)'(0), data_operandB, 1'b0};
                rem      <= '0;
                quot     <= abs_a;
                bmag     <= abs_b;
                neg      <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                div_zero <= (data_operandB == '0);
                div_ovf  <= (data_operandA == {1'b1, (WIDTH - 1)'(0)}) &&
                            (data_operandB == {WIDTH{1'b1}});
                op_div   <= ~ctrl_MULT;
                state    <= ctrl_MULT ? MUL : DIV;
            end else begin
                case (state)
                    MUL: begin
                        prod    <= prod_next;
                        counter <= counter + CW'(1);
                        if (counter == CW'(MULT_CYCLES - 1)) state <= DONE;
                    end
                    DIV: begin
                        rem     <= rem_next;
                        quot    <= quot_next;
                        counter <= counter + CW'(1);
                        if (counter == CW'(DIV_CYCLES - 1)) state <= DONE;
                    end
                    DONE: begin
                        state          <= IDLE;
                        data_resultRDY <= 1'b1;
                        if (!op_div) begin
                            data_result    <= prod[WIDTH:1];
                            data_exception <= mul_exc;
                        end else if (div_zero) begin
                            data_result    <= '0;
                            data_exception <= 1'b1;
                        end else if (div_ovf) begin
                            data_result    <= {1'b1, (WIDTH - 1)'(0)};
                            data_exception <= 1'b1;
                        end else begin
                            data_result    <= div_q;
                            data_exception <= 1'b0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_iter_multdiv.sv
// Bench for iter_multdiv: directed vector table, multi-cycle corner sequences,
// and random signed pairs against a behavioural model.
module tb_iter_multdiv;

    logic        clock;
    logic        reset_n;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;

    int n_checks = 0;
    int n_err    = 0;

    iter_multdiv dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        is_div;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        exc;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Pulse a start on the edge following the current negedge, then release it
    task automatic start_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        ctrl_MULT     = m;
        ctrl_DIV      = d;
        data_operandA = a;
        data_operandB = b;
        @(posedge clock);
        #1;
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
    endtask

    // Wait for RDY with operands scrambled, then check latency, payload and single-cycle strobe
    task automatic wait_rdy(input string name, input int lat, input logic [31:0] res, input logic exc);
        int k;
        k = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clock);
            #1;
            data_operandA = $urandom;
            data_operandB = $urandom;
            if (data_resultRDY) begin
                k = i;
                break;
            end
        end
        chk({name, "_latency"}, 32'(k), 32'(lat));
        chk({name, "_result"}, data_result, res);
        chk({name, "_exc"}, 32'(data_exception), 32'(exc));
        @(posedge clock);
        #1;
        chk({name, "_rdy_single"}, 32'(data_resultRDY), 32'd0);
    endtask

    function automatic void model(input logic d, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic e);
        longint p;
        if (!d) begin
            p = longint'($signed(a)) * longint'($signed(b));
            r = p[31:0];
            e = (p[63:31] != 33'h0) && (p[63:31] != {33{1'b1}});
        end else if (b == 32'h0) begin
            r = 32'h0;
            e = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            r = 32'h8000_0000;
            e = 1'b1;
        end else begin
            r = 32'($signed(a) / $signed(b));
            e = 1'b0;
        end
    endfunction

    vec_t vecs[$];

    initial begin
        logic [31:0] r, a, b;
        logic        e, d;
        int          rdy_cnt;

        vecs.push_back('{1'b0, 32'd3,          32'd4,          32'd12,         1'b0});
        vecs.push_back('{1'b0, 32'hFFFF_FFF9,  32'd6,          32'hFFFF_FFD6,  1'b0});
        vecs.push_back('{1'b0, 32'h7FFF_FFFF,  32'd2,          32'hFFFF_FFFE,  1'b1});
        vecs.push_back('{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1'b1});
        vecs.push_back('{1'b0, 32'h0001_0000,  32'h0001_0000,  32'h0,          1'b1});
        vecs.push_back('{1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          1'b0});
        vecs.push_back('{1'b0, 32'h8000_0000,  32'd1,          32'h8000_0000,  1'b0});
        vecs.push_back('{1'b0, 32'h1234_5678,  32'd0,          32'h0,          1'b0});
        vecs.push_back('{1'b1, 32'd100,        32'd7,          32'd14,         1'b0});
        vecs.push_back('{1'b1, 32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  1'b0});
        vecs.push_back('{1'b1, 32'd7,          32'hFFFF_FF9C,  32'h0,          1'b0});
        vecs.push_back('{1'b1, 32'd5,          32'd0,          32'h0,          1'b1});
        vecs.push_back('{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1'b1});
        vecs.push_back('{1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         1'b0});
        vecs.push_back('{1'b1, 32'h8000_0000,  32'd2,          32'hC000_0000,  1'b0});
        vecs.push_back('{1'b1, 32'hFFFF_FFFF,  32'd2,          32'h0,          1'b0});
        vecs.push_back('{1'b1, 32'd0,          32'd5,          32'h0,          1'b0});
        vecs.push_back('{1'b1, 32'h7FFF_FFFF,  32'd1,          32'h7FFF_FFFF,  1'b0});

        reset_n       = 1'b0;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = 32'h0;
        data_operandB = 32'h0;
        repeat (3) @(posedge clock);
        #1;
        chk("reset_result", data_result, 32'h0);
        chk("reset_exc", 32'(data_exception), 32'd0);
        chk("reset_rdy", 32'(data_resultRDY), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;

        foreach (vecs[i]) begin
            start_op(~vecs[i].is_div, vecs[i].is_div, vecs[i].a, vecs[i].b);
            wait_rdy($sformatf("vec%0d", i), vecs[i].is_div ? 33 : 17, vecs[i].res, vecs[i].exc);
        end

        // Reset in the middle of a divide (counter == 10) aborts it silently
        start_op(1'b0, 1'b1, 32'd100, 32'd7);
        repeat (10) @(posedge clock);
        #1;
        reset_n = 1'b0;
        #2;
        chk("midreset_result", data_result, 32'h0);
        chk("midreset_exc", 32'(data_exception), 32'd0);
        chk("midreset_rdy", 32'(data_resultRDY), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        rdy_cnt = 0;
        repeat (40) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) rdy_cnt++;
        end
        chk("midreset_no_rdy", 32'(rdy_cnt), 32'd0);
        start_op(1'b1, 1'b0, 32'd3, 32'd4);
        wait_rdy("post_reset_mult", 17, 32'd12, 1'b0);

        // Restart: a MULT pulse 10 cycles into a DIV replaces it
        start_op(1'b0, 1'b1, 32'd100, 32'd7);
        rdy_cnt = 0;
        repeat (9) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) rdy_cnt++;
        end
        start_op(1'b1, 1'b0, 32'd5, 32'd5);
        if (data_resultRDY) rdy_cnt++;
        chk("restart_no_early_rdy", 32'(rdy_cnt), 32'd0);
        wait_rdy("restart_mult", 17, 32'd25, 1'b0);
        rdy_cnt = 0;
        repeat (20) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) rdy_cnt++;
        end
        chk("restart_no_stale_rdy", 32'(rdy_cnt), 32'd0);

        // Simultaneous starts: multiply takes priority
        start_op(1'b1, 1'b1, 32'd9, 32'd3);
        wait_rdy("both_start", 17, 32'd27, 1'b0);

        for (int i = 0; i < 240; i++) begin
            d = i[0];
            a = (i % 5 == 0) ? 32'($urandom_range(0, 200)) - 32'd100 : 32'($urandom);
            b = (i % 3 == 0) ? 32'($urandom_range(0, 20)) - 32'd10 : 32'($urandom);
            model(d, a, b, r, e);
            start_op(~d, d, a, b);
            wait_rdy($sformatf("rand%0d", i), d ? 33 : 17, r, e);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
